tmds_mode_switcher: RTL

TMDS_MODE_SWITCHER -- requirements
Module: tmds_mode_switcher

---
 rtl/tmds_mode_switcher.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tmds_mode_switcher.sv
// Glitch-free switch between several TMDS timing generators: waits for the old
// mode's frame boundary (or a timeout), then blanks MUTE_FRAMES new-mode frames.
module tmds_mode_switcher #(
  parameter int NUM_MODES      = 2,
  parameter int NUM_CHANNELS   = 3,
  parameter int MUTE_FRAMES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int RESET_MODE     = 0,
  localparam int MW = $clog2(NUM_MODES),
  localparam int CW = NUM_CHANNELS * 10,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1),
  localparam int FW = $clog2(MUTE_FRAMES + 1)
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic [NUM_MODES*CW-1:0]       tmds_channels_in,
  input  logic [NUM_MODES*12-1:0]       cx_in,
  input  logic [NUM_MODES*11-1:0]       cy_in,
  input  logic [NUM_MODES-1:0]          frame_start,
  input  logic [MW-1:0]                 mode_sel,
  output logic [CW-1:0]                 tmds_channels_out,
  output logic [11:0]                   cx,
  output logic [10:0]                   cy,
  output logic [MW-1:0]                 active_mode,
  output logic                          switching,
  output logic                          timeout_flag
);

  localparam logic [9:0] BLANK_SYM = 10'b1101010100;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    WAIT_EOF = 2'd1,
    MUTE     = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [MW-1:0]   active_q,    active_d;
  logic [MW-1:0]   target_q,    target_d;
  logic [FW-1:0]   frames_q,    frames_d;
  logic [TW-1:0]   timer_q,     timer_d;
  logic            tflag_q,     tflag_d;
  logic            switching_q, switching_d;
  logic [CW-1:0]   tmds_q,      tmds_d;
  logic [11:0]     cx_q,        cx_d;
  logic [10:0]     cy_q,        cy_d;

  logic            sel_valid;
  logic            sel_differs;
  logic            fs_active;
  logic            timeout_hit;
  logic [MW-1:0]   new_target;

  // Out-of-range requests are ignored everywhere, so validity gates every use of mode_sel.
  assign sel_valid   = ({1'b0, mode_sel} < (MW+1)'(NUM_MODES));
  assign sel_differs = sel_valid && (mode_sel != active_q);
  assign fs_active   = frame_start[active_q];
  assign timeout_hit = (timer_q >= TW'(TIMEOUT_CYCLES - 1));
  assign new_target  = sel_valid ? mode_sel : target_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    frames_d = frames_q;
    timer_d  = timer_q;
    tflag_d  = tflag_q;

    unique case (state_q)
      LOCKED: begin
        if (sel_differs) begin
          target_d = mode_sel;
          timer_d  = '0;
          state_d  = WAIT_EOF;
        end
      end

      WAIT_EOF: begin
        if (timer_q != TW'(TIMEOUT_CYCLES)) timer_d = timer_q + 1'b1;
        if (sel_valid && (mode_sel == active_q)) begin
          state_d = LOCKED;
        end else begin
          target_d = new_target;
          if (fs_active || timeout_hit) begin
            state_d  = MUTE;
            active_d = new_target;
            frames_d = '0;
            if (!fs_active) tflag_d = 1'b1;
          end
        end
      end

      MUTE: begin
        // Output is already blank, so a new request switches at once.
        if (sel_differs) begin
          active_d = mode_sel;
          frames_d = '0;
        end else if (fs_active) begin
          if (frames_q == FW'(MUTE_FRAMES - 1)) state_d = LOCKED;
          else                                  frames_d = frames_q + 1'b1;
        end
      end

      default: state_d = MUTE;
    endcase
  end

  // Datapath follows the next state so the registered mode and data always agree.
  always_comb begin
    tmds_d      = {NUM_CHANNELS{BLANK_SYM}};
    cx_d        = '0;
    cy_d        = '0;
    switching_d = (state_d != LOCKED);
    for (int m = 0; m < NUM_MODES; m++) begin
      if (active_d == MW'(m)) begin
        cx_d = cx_in[m*12 +: 12];
        cy_d = cy_in[m*11 +: 11];
        if (state_d != MUTE) tmds_d = tmds_channels_in[m*CW +: CW];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MUTE;
      active_q    <= MW'(RESET_MODE);
      target_q    <= MW'(RESET_MODE);
      frames_q    <= '0;
      timer_q     <= '0;
      tflag_q     <= 1'b0;
      switching_q <= 1'b1;
      tmds_q      <= {NUM_CHANNELS{BLANK_SYM}};
      cx_q        <= '0;
      cy_q        <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      target_q    <= target_d;
      frames_q    <= frames_d;
      timer_q     <= timer_d;
      tflag_q     <= tflag_d;
      switching_q <= switching_d;
      tmds_q      <= tmds_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
    end
  end

  assign tmds_channels_out = tmds_q;
  assign cx                = cx_q;
  assign cy                = cy_q;
  assign active_mode       = active_q;
  assign switching         = switching_q;
  assign timeout_flag      = tflag_q;

endmodule
